// File: rtl/sd_controller_pkg.sv
// Shared types and constants for the SD controller card-read path.
// Property flag positions are offsets counted down from the MSB of the property word.
package sd_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUF,
    ST_FILL,
    ST_DRAIN,
    ST_COMMIT,
    ST_DONE
  } rx_seq_state_t;

  localparam int PROP_CRC_ERR_BIT = 0;
  localparam int PROP_LEN_ERR_BIT = 1;
  localparam int PROP_LAST_BIT    = 2;

  localparam int SD_BLOCK_WORDS = 128;

endpackage

// File: rtl/sd_controller_rx_block_sequencer.sv
// Places received blocks into the free half of the ping-pong buffer and commits each
// block with a property word; stalls the receiver while no buffer half is free.
module sd_controller_rx_block_sequencer
  import sd_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = $clog2(SD_BLOCK_WORDS),
  parameter int DATA_WIDTH = 32,
  parameter int PROP_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  block_count,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic                  s_crc_err,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] buf_waddr,
  output logic [DATA_WIDTH-1:0] buf_wdata,
  output logic                  buf_we,
  output logic [PROP_WIDTH-1:0] buf_wprop,
  output logic                  buf_wupdate,
  input  logic                  buf_wvalid,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_err_seen
);

  rx_seq_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [CNT_WIDTH-1:0]  blk_idx_reg, blk_idx_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic                  crc_reg, crc_next;
  logic                  len_err_reg, len_err_next;
  logic                  overflow_reg, overflow_next;
  logic                  crc_err_seen_reg, crc_err_seen_next;
  logic                  beat, at_last_addr, last_block;

  // Ready is a function of state and buffer availability only, never of s_valid.
  assign s_ready      = (state_reg == ST_FILL) ? buf_wvalid : (state_reg == ST_DRAIN);
  assign beat         = s_valid & s_ready;
  assign at_last_addr = (addr_reg == '1);
  assign last_block   = (blk_idx_reg == count_reg - CNT_WIDTH'(1));

  assign buf_waddr    = addr_reg;
  assign buf_wdata    = s_data;
  assign busy         = (state_reg != ST_IDLE);
  assign crc_err_seen = crc_err_seen_reg;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      blk_idx_reg      <= '0;
      count_reg        <= '0;
      crc_reg          <= 1'b0;
      len_err_reg      <= 1'b0;
      overflow_reg     <= 1'b0;
      crc_err_seen_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      blk_idx_reg      <= blk_idx_next;
      count_reg        <= count_next;
      crc_reg          <= crc_next;
      len_err_reg      <= len_err_next;
      overflow_reg     <= overflow_next;
      crc_err_seen_reg <= crc_err_seen_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    blk_idx_next      = blk_idx_reg;
    count_next        = count_reg;
    crc_next          = crc_reg;
    len_err_next      = len_err_reg;
    overflow_next     = overflow_reg;
    crc_err_seen_next = crc_err_seen_reg;
    buf_we            = 1'b0;
    buf_wupdate       = 1'b0;
    buf_wprop         = '0;
    done              = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          count_next        = block_count;
          crc_err_seen_next = 1'b0;
          blk_idx_next      = '0;
          addr_next         = '0;
          crc_next          = 1'b0;
          len_err_next      = 1'b0;
          overflow_next     = 1'b0;
          state_next        = (block_count != '0) ? ST_WAIT_BUF : ST_DONE;
        end
      end
      ST_WAIT_BUF: begin
        if (abort)           state_next = ST_IDLE;
        else if (buf_wvalid) state_next = ST_FILL;
      end
      ST_FILL: begin
        if (beat) begin
          buf_we    = 1'b1;
          addr_next = addr_reg + ADDR_WIDTH'(1);
          if (s_last) begin
            crc_next     = s_crc_err;
            len_err_next = !at_last_addr;
            state_next   = ST_COMMIT;
          end else if (at_last_addr) begin
            overflow_next = 1'b1;
            state_next    = ST_DRAIN;
          end
        end
        if (abort) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        // Excess words past the block end are swallowed until s_last.
        if (beat && s_last) begin
          crc_next     = s_crc_err;
          len_err_next = 1'b1;
          state_next   = ST_COMMIT;
        end
        if (abort) state_next = ST_IDLE;
      end
      ST_COMMIT: begin
        buf_wupdate                                  = 1'b1;
        buf_wprop[CNT_WIDTH-1:0]                     = blk_idx_reg;
        buf_wprop[PROP_WIDTH-1-PROP_CRC_ERR_BIT]     = crc_reg;
        buf_wprop[PROP_WIDTH-1-PROP_LEN_ERR_BIT]     = len_err_reg;
        buf_wprop[PROP_WIDTH-1-PROP_LAST_BIT]        = last_block;
        crc_err_seen_next = crc_err_seen_reg | crc_reg;
        blk_idx_next      = blk_idx_reg + CNT_WIDTH'(1);
        addr_next         = '0;
        crc_next          = 1'b0;
        len_err_next      = 1'b0;
        overflow_next     = 1'b0;
        // buf_wvalid is registered in the buffer, so always go back and re-check it.
        if (abort)           state_next = ST_IDLE;
        else if (last_block) state_next = ST_DONE;
        else                 state_next = ST_WAIT_BUF;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_controller_rx_block_sequencer.sv
// Directed bench for the RX block sequencer: normal transfers, backpressure, short/long
// blocks, CRC flagging, zero-count start, abort and mid-transfer reset.
module tb_sd_controller_rx_block_sequencer;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] block_count = '0;
  logic          abort = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_crc_err = 1'b0;
  logic          s_ready;
  logic [AW-1:0] buf_waddr;
  logic [DW-1:0] buf_wdata;
  logic          buf_we;
  logic [PW-1:0] buf_wprop;
  logic          buf_wupdate;
  logic          buf_wvalid = 1'b0;
  logic          busy;
  logic          done;
  logic          crc_err_seen;

  always #5 aclk = ~aclk;

  sd_controller_rx_block_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROP_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .areset(areset), .start(start), .block_count(block_count),
    .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_crc_err(s_crc_err), .s_ready(s_ready), .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_wprop(buf_wprop),
    .buf_wupdate(buf_wupdate), .buf_wvalid(buf_wvalid), .busy(busy),
    .done(done), .crc_err_seen(crc_err_seen)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0, we_cnt = 0, upd_cnt = 0, done_cnt = 0, drain_cnt = 0;
  int upd_cyc = 0, done_cyc = 0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [PW-1:0] props [$];

  // Buffer-side observer, sampled mid-cycle.
  always @(negedge aclk) begin
    cyc++;
    if (buf_we) begin
      mem[buf_waddr] = buf_wdata;
      we_cnt++;
    end
    if (s_valid && s_ready && !buf_we) drain_cnt++;
    if (buf_wupdate) begin
      props.push_back(buf_wprop);
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_start(input int n);
    block_count = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input bit last, input bit crc);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      s_valid   = 1'b1;
      s_data    = DW'(base + i);
      s_last    = last && (i == n - 1);
      s_crc_err = crc && last && (i == n - 1);
      while (!s_ready && t < 200) begin
        tick();
        t++;
      end
      if (t >= 200) begin
        chk("ready_timeout", 64'(s_ready), 64'd1);
        break;
      end
      tick();
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_crc_err = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base, t;
    base = done_cnt;
    t = 0;
    while (done_cnt == base && t < 300) begin
      tick();
      t++;
    end
    chk(tag, 64'(done_cnt - base), 64'd1);
  endtask

  task automatic chk_prop(input string tag, input logic [PW-1:0] exp);
    logic [PW-1:0] v;
    v = 'x;
    if (props.size() != 0) v = props.pop_front();
    chk(tag, 64'(v), 64'(exp));
  endtask

  initial begin
    int we0, u0, d0, dr0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(buf_we), 64'd0);
    chk("rst_upd", 64'(buf_wupdate), 64'd0);
    chk("rst_crc_seen", 64'(crc_err_seen), 64'd0);
    chk("rst_waddr", 64'(buf_waddr), 64'd0);
    chk("rst_wprop", 64'(buf_wprop), 64'd0);
    areset = 1'b0;
    tick();

    // Basic: two full blocks, buffer always free
    buf_wvalid = 1'b1;
    we0 = we_cnt; u0 = upd_cnt; d0 = done_cnt;
    do_start(2);
    chk("basic_busy", 64'(busy), 64'd1);
    send_words(128, 32'h1000, 1'b1, 1'b0);
    chk("basic_b0_w0", 64'(mem[0]), 64'h1000);
    chk("basic_b0_w127", 64'(mem[127]), 64'h107f);
    send_words(128, 32'h2000, 1'b1, 1'b0);
    wait_done("basic_done");
    chk("basic_we_cnt", 64'(we_cnt - we0), 64'd256);
    chk("basic_upd_cnt", 64'(upd_cnt - u0), 64'd2);
    chk_prop("basic_prop0", 32'h0000_0000);
    chk_prop("basic_prop1", 32'h2000_0001);
    chk("basic_done_lat", 64'(done_cyc - upd_cyc), 64'd1);
    chk("basic_b1_w5", 64'(mem[5]), 64'h2005);
    chk("basic_idle", 64'(busy), 64'd0);
    chk("basic_done_once", 64'(done_cnt - d0), 64'd1);

    // Backpressure: buffer held busy for 50 cycles after the first commit
    we0 = we_cnt;
    do_start(2);
    send_words(128, 32'h2800, 1'b1, 1'b0);
    buf_wvalid = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hdead_0000;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_ready_low", 64'(s_ready), 64'd0);
    end
    chk("bp_no_we", 64'(we_cnt - we0), 64'd128);
    buf_wvalid = 1'b1;
    send_words(128, 32'h3000, 1'b1, 1'b0);
    wait_done("bp_done");
    chk("bp_we_cnt", 64'(we_cnt - we0), 64'd256);
    chk_prop("bp_prop0", 32'h0000_0000);
    chk_prop("bp_prop1", 32'h2000_0001);
    chk("bp_w0", 64'(mem[0]), 64'h3000);
    chk("bp_w127", 64'(mem[127]), 64'h307f);

    // Short block: s_last on word 99
    we0 = we_cnt;
    do_start(2);
    send_words(100, 32'h4000, 1'b1, 1'b0);
    chk("short_w99", 64'(mem[99]), 64'h4063);
    chk("short_we_cnt", 64'(we_cnt - we0), 64'd100);
    send_words(128, 32'h5000, 1'b1, 1'b0);
    wait_done("short_done");
    chk_prop("short_prop0", 32'h4000_0000);
    chk_prop("short_prop1", 32'h2000_0001);
    chk("short_addr_restart", 64'(mem[0]), 64'h5000);
    chk("short_we_total", 64'(we_cnt - we0), 64'd228);

    // Long block: 140 words, last 12 discarded
    we0 = we_cnt; dr0 = drain_cnt;
    do_start(1);
    send_words(140, 32'h6000, 1'b1, 1'b0);
    wait_done("long_done");
    chk("long_we_cnt", 64'(we_cnt - we0), 64'd128);
    chk("long_drained", 64'(drain_cnt - dr0), 64'd12);
    chk("long_w127", 64'(mem[127]), 64'h607f);
    chk_prop("long_prop", 32'h6000_0000);

    // CRC error on a single block, then zero-count start
    do_start(1);
    send_words(128, 32'h7000, 1'b1, 1'b1);
    wait_done("crc_done");
    chk_prop("crc_prop", 32'ha000_0000);
    chk("crc_seen", 64'(crc_err_seen), 64'd1);
    we0 = we_cnt; u0 = upd_cnt;
    do_start(0);
    chk("zero_done_pulse", 64'(done), 64'd1);
    tick();
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_idle", 64'(busy), 64'd0);
    chk("zero_no_we", 64'(we_cnt - we0), 64'd0);
    chk("zero_no_upd", 64'(upd_cnt - u0), 64'd0);

    // Abort on word 60 of block 1
    u0 = upd_cnt; d0 = done_cnt;
    do_start(3);
    chk("abort_seen_cleared", 64'(crc_err_seen), 64'd0);
    send_words(128, 32'h8000, 1'b1, 1'b0);
    send_words(60, 32'h9000, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data = 32'h903c;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("abort_upd_cnt", 64'(upd_cnt - u0), 64'd1);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk_prop("abort_prop0", 32'h0000_0000);

    // start and abort together in IDLE: start wins; then abort from WAIT_BUF/FILL
    block_count = CW'(1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins", 64'(busy), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_early", 64'(busy), 64'd0);

    // Reset mid-FILL
    u0 = upd_cnt; d0 = done_cnt;
    do_start(2);
    send_words(30, 32'ha000, 1'b0, 1'b0);
    areset = 1'b1;
    tick();
    chk("rst_mid_idle", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(s_ready), 64'd0);
    areset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_mid_no_upd", 64'(upd_cnt - u0), 64'd0);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("props_drained", 64'(props.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_controller_rx_block_sequencer.md
Name: sd_controller_rx_block_sequencer

Overview:
Write-side sequencer for the SD controller's ping-pong block buffer on the card-read path. It takes a word stream from the DAT-line receiver and places each block of words into the free buffer half. At the end of each block it commits the block with a property word (block index and status flags), and it stalls the receiver while no buffer half is free. A transfer is started by the command engine, runs for a programmed block count, and can be aborted.

Parameters:
ADDR_WIDTH, 7, word address width; block size is 2**ADDR_WIDTH words (128 x 32 bit = 512 B).
DATA_WIDTH, 32, stream and buffer word width.
PROP_WIDTH, 32, buffer property width; must be >= CNT_WIDTH+3.
CNT_WIDTH, 16, block counter width.

Ports:
aclk  in  1  clock
areset  in  1  reset
start  in  1  start pulse; accepted only in IDLE
block_count  in  CNT_WIDTH  blocks to transfer; sampled on an accepted start
abort  in  1  cancel the transfer in progress
s_data  in  DATA_WIDTH  receiver word
s_valid  in  1  receiver word valid
s_last  in  1  last word of block; qualified by s_valid
s_crc_err  in  1  block CRC failed; qualified by s_valid&s_last
s_ready  out  1  sequencer accepts a word
buf_waddr  out  ADDR_WIDTH  buffer write address
buf_wdata  out  DATA_WIDTH  buffer write data
buf_we  out  1  buffer write enable
buf_wprop  out  PROP_WIDTH  block property
buf_wupdate  out  1  commit the current buffer half
buf_wvalid  in  1  write half of the buffer is free
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when all blocks are committed
crc_err_seen  out  1  sticky; set by any block with CRC error, cleared on an accepted start

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset forces state=IDLE, addr=0, blk_idx=0, crc_err_seen=0, overflow=0. All outputs read 0 (buf_wdata mirrors s_data).
- States: IDLE, WAIT_BUF, FILL, DRAIN, COMMIT, DONE.
- IDLE:
  - s_ready=0.
  - start with block_count!=0: latch the count, clear crc_err_seen, blk_idx=0, addr=0, go to WAIT_BUF.
  - start with block_count==0: go to DONE (done pulses 1 cycle later, no buffer activity).
- WAIT_BUF: s_ready=0. buf_wvalid=1 -> FILL.
- FILL:
  - s_ready=buf_wvalid (combinational).
  - A beat is s_valid&s_ready. On a beat, the same cycle drives buf_we=1, buf_waddr=addr, buf_wdata=s_data; then addr++.
  - Beat with s_last: latch crc=s_crc_err; set len_err if addr != 2**ADDR_WIDTH-1; go to COMMIT.
  - Beat at addr==2**ADDR_WIDTH-1 without s_last: set overflow, go to DRAIN.
- DRAIN:
  - s_ready=1, buf_we=0; words are discarded.
  - Beat with s_last: latch crc, len_err=1, go to COMMIT.
- COMMIT:
  - Exactly one cycle with buf_wupdate=1.
  - buf_wprop layout: [CNT_WIDTH-1:0]=blk_idx, [PROP_WIDTH-1]=crc, [PROP_WIDTH-2]=len_err, [PROP_WIDTH-3]=last_block; all other bits 0.
  - crc_err_seen |= crc. blk_idx++, addr=0, flags cleared.
  - Next state: DONE if this was the last block, else WAIT_BUF. buf_wvalid is registered in the buffer, so it is always re-checked; this gives one bubble cycle per block.
- DONE: done=1 for one cycle, then IDLE.
- Handshake: s_ready never depends on s_valid. buf_we never asserts outside FILL.
- abort:
  - In WAIT_BUF, FILL or DRAIN: go to IDLE next cycle. The partial block is never committed and done is not pulsed.
  - In COMMIT: the commit completes that cycle, then IDLE. done is not pulsed.
  - In DONE: ignored.
  - In IDLE: ignored; start and abort together in IDLE -> start wins.
- start while busy: ignored.
- blk_idx wraps modulo 2**CNT_WIDTH.
- Reset mid-transfer: immediate return to IDLE with no commit.

Decomposition:
- Shared package sd_controller_pkg holds:
  - the state enum rx_seq_state_t;
  - the PROP bit positions PROP_CRC_ERR_BIT, PROP_LEN_ERR_BIT, PROP_LAST_BIT as offsets from PROP_WIDTH-1;
  - the block-size constant SD_BLOCK_WORDS.
- Single module with no sub-module. FSM, address counter and block counter are all in one file.

Test Plan:
- Basic: count=2, 128 valid words/block with s_last on word 127, buf_wvalid=1 -> 256 buf_we, two buf_wupdate with prop idx 0 then idx 1 plus last bit (0x20000001), done 1 cycle after the second commit.
- Backpressure: buf_wvalid held 0 for 50 cycles after the first commit -> s_ready=0 for all 50 cycles, no buf_we, no data loss; block 1 completes once buf_wvalid returns.
- Short block: s_last on word 99 -> commit with len_err bit set (0x40000000 | idx), addr restarts at 0 for the next block.
- Long block: 140 words, s_last on word 139 -> 128 writes, 12 discarded with s_ready=1, prop has len_err set.
- CRC: block 0 with s_crc_err=1 -> prop bit 31 set, crc_err_seen=1 until the next start; count=0 start -> done 1 cycle later, no buf_we or buf_wupdate.
- Abort: abort on word 60 of block 1 -> IDLE next cycle, no buf_wupdate, no done, busy=0; reset asserted mid-FILL gives the same result.
